io_stream_loader: RTL and testbench

- Upstream sequencer of the IO module. It accepts a host word stream: a header word holding the count N, then N data words.
- Each data word is written to the solver's data memory at consecutive addresses.
- It drives the load/decrement interface of the downstream down-counter (cnt_d/cnt_load/cnt_new), so the counter tracks the words still outstanding.
- It reports completion or a count error to the IO controller.

---
 rtl/io_pkg.sv | 7 +
 rtl/io_stream_write_reg.sv | 32 +++
 rtl/io_stream_loader.sv | 105 ++++++++++
 tb/tb_io_stream_loader.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// io_pkg: shared state encoding and default sizes for the IO stream loader.
package io_pkg;
  typedef enum logic [2:0] {IDLE, HDR, DATA, CHK, ERR, DONE} state_t;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 10;
  localparam int MAX_WORDS_DEF = 1024;
endpackage

// File: rtl/io_stream_write_reg.sv
// io_stream_write_reg: one-stage output register for memory writes and counter decrements.
module io_stream_write_reg
  import io_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              cnt_new
);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      cnt_new   <= 1'b0;
    end else begin
      mem_we  <= wr;
      cnt_new <= wr;
      if (wr) begin
        mem_addr  <= addr;
        mem_wdata <= data;
      end
    end
endmodule

// File: rtl/io_stream_loader.sv
// io_stream_loader: loads a header+N word stream into data memory and drives the down-counter.
// Optional trailing checksum word enabled by ODE_LOADER_CHECKSUM_EN.
module io_stream_loader
  import io_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int BASE_ADDR = 0,
  parameter int MAX_WORDS = MAX_WORDS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic [DATA_W-1:0] cnt_d,
  output logic              cnt_load,
  output logic              cnt_new,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              chk_err
);
`ifdef ODE_LOADER_CHECKSUM_EN
  localparam state_t FIN = CHK;
`else
  localparam state_t FIN = DONE;
`endif
  state_t state, state_nx;
  logic [ADDR_W-1:0] idx;
  logic [DATA_W-1:0] rem;
  logic acc, big, last, hdr_acc, dat_acc;
  assign in_ready = state == HDR || state == DATA || state == CHK;
  assign acc      = in_valid && in_ready;
  assign hdr_acc  = acc && state == HDR;
  assign dat_acc  = acc && state == DATA;
  assign busy     = state != IDLE;
  assign done     = state == DONE;
  assign big      = in_data > DATA_W'(MAX_WORDS);
  assign last     = rem == DATA_W'(1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? HDR : IDLE;
      HDR:     if (acc) state_nx = big ? ERR : in_data == '0 ? FIN : DATA;
      DATA:    if (acc && last) state_nx = FIN;
      CHK:     if (acc) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      idx      <= '0;
      rem      <= '0;
      cnt_d    <= '0;
      cnt_load <= 1'b0;
      err      <= 1'b0;
    end else begin
      cnt_load <= hdr_acc && !big;
      if (state == IDLE && start) err <= 1'b0;
      if (hdr_acc) begin
        idx <= '0;
        rem <= in_data;
        if (big) err <= 1'b1;
        else cnt_d <= in_data;
      end
      if (dat_acc) begin
        idx <= idx + ADDR_W'(1);
        if (rem != '0) rem <= rem - DATA_W'(1);
      end
    end
`ifdef ODE_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sum     <= '0;
      chk_err <= 1'b0;
    end else begin
      if (state == IDLE && start) chk_err <= 1'b0;
      if (hdr_acc) sum <= '0;
      if (dat_acc) sum <= sum + in_data;
      if (acc && state == CHK && in_data != sum) chk_err <= 1'b1;
    end
`else
  assign chk_err = 1'b0;
`endif
  io_stream_write_reg #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_wr (
    .clk      (clk),
    .rst      (rst),
    .wr       (dat_acc),
    .addr     (ADDR_W'(BASE_ADDR) + idx),
    .data     (in_data),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we   (mem_we),
    .cnt_new  (cnt_new)
  );
endmodule

// File: tb/tb_io_stream_loader.sv
// tb_io_stream_loader: randomized directed bench for io_stream_loader against a word-list model.
module tb_io_stream_loader;
  localparam int DW = 32, AW = 10, BASE = 1021, MAXW = 1024;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic in_ready, mem_we, cnt_load, cnt_new, busy, done, err, chk_err;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, cnt_d, load_val;
  int checks = 0, errors = 0;
  int cyc = 0, n_load, n_new, n_done, both, busy_gap, load_cyc, done_cyc, we_cyc;
  logic active = 1'b0;
  logic [AW+DW-1:0] wq[$];
  logic [DW-1:0] words[$];

  always #5 clk = ~clk;

  io_stream_loader #(.DATA_W(DW), .ADDR_W(AW), .BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .cnt_d(cnt_d), .cnt_load(cnt_load), .cnt_new(cnt_new), .busy(busy), .done(done),
    .err(err), .chk_err(chk_err)
  );

  always @(negedge clk) begin
    cyc++;
    if (mem_we) begin
      wq.push_back({mem_addr, mem_wdata});
      we_cyc = cyc;
    end
    if (cnt_load) begin
      n_load++;
      load_val = cnt_d;
      load_cyc = cyc;
    end
    if (cnt_new) n_new++;
    if (done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (cnt_load && cnt_new) both++;
    if (cnt_new && n_load == 0) both++;
    if (active && !busy) busy_gap++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clr();
    wq.delete();
    n_load = 0; n_new = 0; n_done = 0; both = 0; busy_gap = 0;
    load_cyc = -1; done_cyc = -1; we_cyc = -1;
  endtask

  task automatic send(input logic [DW-1:0] w, input bit noise);
    int t = 0;
    in_valid = 1'b1;
    in_data = w;
    start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic xfer(input int n, input int gmin, input int gmax, input bit noise, input bit bad_sum);
    logic [DW-1:0] sum = '0;
    logic [AW-1:0] a;
    bit big = n > MAXW;
    bit exp_chk = 1'b0;
    int exp_wr = big ? 0 : n;
    words.delete();
    clr();
    start = 1'b1;
    idle(1);
    start = 1'b0;
    active = 1'b1;
    chk("err_clr", err, 0);
    chk("chk_err_clr", chk_err, 0);
    chk("busy_hdr", busy, 1);
    send(DW'(n), noise);
    for (int i = 0; i < exp_wr; i++) begin
      words.push_back($urandom);
      sum += words[i];
      idle($urandom_range(gmin, gmax));
      send(words[i], noise);
    end
`ifdef ODE_LOADER_CHECKSUM_EN
    if (!big) send(bad_sum ? sum + 1 : sum, noise);
    exp_chk = bad_sum && !big;
`endif
    active = 1'b0;
    idle(4);
    chk("n_writes", wq.size(), exp_wr);
    for (int i = 0; i < wq.size() && i < exp_wr; i++) begin
      a = AW'(BASE + i);
      chk("write", wq[i], {a, words[i]});
    end
    chk("n_load", n_load, big ? 0 : 1);
    if (!big) chk("cnt_d", load_val, n);
    chk("n_new", n_new, exp_wr);
    chk("n_done", n_done, big ? 0 : 1);
    chk("err", err, big);
    chk("chk_err", chk_err, exp_chk);
    chk("cnt_order", both, 0);
    chk("busy_gap", busy_gap, 0);
    chk("busy_end", busy, 0);
`ifndef ODE_LOADER_CHECKSUM_EN
    if (!big) chk("done_align", done_cyc, n == 0 ? load_cyc : we_cyc);
`endif
  endtask

  initial begin
    idle(3);
    chk("rst_outs", {in_ready, mem_we, cnt_load, cnt_new, busy, done, err, chk_err, mem_addr, mem_wdata, cnt_d}, 0);
    rst = 1'b1;
    idle(2);
    xfer(3, 0, 0, 0, 0);
    xfer(2, 2, 2, 0, 0);
    xfer(0, 0, 0, 0, 0);
    xfer(MAXW + 1, 0, 0, 0, 0);
    idle(3);
    chk("err_sticky", err, 1);
    xfer(5, 0, 1, 0, 0);
    clr();
    start = 1'b1;
    idle(1);
    start = 1'b0;
    send(DW'(4), 0);
    send($urandom, 0);
    chk("we_pre_rst", mem_we, 1);
    rst = 1'b0;
    #1;
    chk("rst_async", {in_ready, mem_we, cnt_load, cnt_new, busy, done, err, chk_err, mem_addr, mem_wdata, cnt_d}, 0);
    idle(2);
    rst = 1'b1;
    wq.delete();
    idle(6);
    chk("no_wr_after_rst", wq.size(), 0);
    chk("idle_after_rst", busy, 0);
    for (int k = 0; k < 6; k++) xfer($urandom_range(1, 20), 0, 2, 1, k[0]);
    xfer(MAXW, 0, 0, 0, 0);
    xfer(3, 0, 0, 0, 0);
    xfer(3, 0, 1, 0, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
